// File: rtl/axi_rr_lock_mux.sv
// Round-robin arbiter for NUM valid/ready/last sources onto one sender channel.
// The grant is locked for a whole burst; the payload path is a one-hot AND-OR mux.
module axi_rr_lock_mux #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM     = 4,
  parameter int unsigned OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM-1:0]   src_valid,
  input  logic [WIDTH-1:0] src_data [0:NUM-1],
  input  logic [NUM-1:0]   src_last,
  output logic [NUM-1:0]   src_ready,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data,
  output logic             dst_last,
  input  logic             dst_ready,
  output logic [NUM-1:0]   grant,
  output logic             busy
);

  localparam int unsigned IW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int unsigned CW = IW + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_next;
  logic [NUM-1:0]   grant_next;
  logic [IW-1:0]    rr_ptr, rr_ptr_next;
  logic [IW-1:0]    gidx, gidx_next;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [CW-1:0]    cand;

  logic             mux_valid;
  logic             mux_last;
  logic [WIDTH-1:0] mux_data;
  logic             in_ready;
  logic             accept;

  // Scan from rr_ptr upward; the extra index bit lets the wrap use a plain compare.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM; off++) begin
      cand = {1'b0, rr_ptr} + CW'(off);
      if (cand > CW'(NUM - 1)) cand = cand - CW'(NUM);
      if (!win_found && src_valid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    mux_data = '0;
    mux_last = 1'b0;
    for (int unsigned k = 0; k < NUM; k++) begin
      mux_data = mux_data | ({WIDTH{grant[k]}} & src_data[k]);
      mux_last = mux_last | (grant[k] & src_last[k]);
    end
  end

  assign mux_valid = |(grant & src_valid);
  assign src_ready = grant & {NUM{in_ready}};
  assign accept    = mux_valid & in_ready;
  assign busy      = (state == LOCKED);

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    rr_ptr_next = rr_ptr;
    gidx_next   = gidx;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next          = LOCKED;
          grant_next          = '0;
          grant_next[win_idx] = 1'b1;
          gidx_next           = win_idx;
        end
      end
      LOCKED: begin
        if (accept && mux_last) begin
          state_next  = IDLE;
          grant_next  = '0;
          rr_ptr_next = (gidx == IW'(NUM - 1)) ? '0 : gidx + IW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      gidx   <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_ptr_next;
      gidx   <= gidx_next;
    end
  end

  if (OUT_REG == 0) begin : g_comb
    assign in_ready  = dst_ready;
    assign dst_valid = mux_valid;
    assign dst_data  = mux_data;
    assign dst_last  = mux_last;
  end else begin : g_slice
    // Two-entry FIFO: ready depends only on its own fill level, so no
    // combinational path runs from dst_ready back to src_ready.
    logic [WIDTH:0] mem [0:1];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     count;
    logic           push, pop;

    assign in_ready  = (count != 2'd2);
    assign push      = accept;
    assign pop       = dst_valid & dst_ready;
    assign dst_valid = (count != 2'd0);
    assign dst_last  = mem[rd_ptr][WIDTH];
    assign dst_data  = mem[rd_ptr][WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem[0] <= '0;
        mem[1] <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {mux_last, mux_data};
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_rr_lock_mux.sv
// Scoreboard bench: a combinational-output instance and a skid-slice instance
// share source stimulus; expected beats are queued in arbitration order.
module tb_axi_rr_lock_mux;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NUM   = 4;

  typedef struct packed {
    logic             v;
    logic             l;
    logic [WIDTH-1:0] d;
  } beat_t;

  typedef struct {
    int unsigned    cyc;
    logic [NUM-1:0] g;
  } stamp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NUM-1:0]   src_valid;
  logic [WIDTH-1:0] src_data [0:NUM-1];
  logic [NUM-1:0]   src_last;

  logic [NUM-1:0]   src_ready0, src_ready1;
  logic             dst_valid0, dst_valid1;
  logic [WIDTH-1:0] dst_data0, dst_data1;
  logic             dst_last0, dst_last1;
  logic             dst_ready0, dst_ready1;
  logic [NUM-1:0]   grant0, grant1;
  logic             busy0, busy1;

  beat_t            srcq [NUM][$];
  logic [WIDTH:0]   exp0 [$];
  logic [WIDTH:0]   exp1 [$];
  stamp_t           stamps [$];

  logic [NUM-1:0]   hs = '0;
  logic [NUM-1:0]   pres_beat = '0;
  logic [NUM-1:0]   pres_bub = '0;
  logic             bp_phase = 1'b0;
  logic             mon0_en = 1'b1;
  int unsigned      cyc = 0;
  int unsigned      n_checks = 0;
  int unsigned      n_errors = 0;

  logic             stall_prev = 1'b0;
  logic [WIDTH+1:0] out1_prev = '0;

  always #5 clk = ~clk;

  axi_rr_lock_mux #(.WIDTH(WIDTH), .NUM(NUM), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready0),
    .dst_valid(dst_valid0), .dst_data(dst_data0), .dst_last(dst_last0), .dst_ready(dst_ready0),
    .grant(grant0), .busy(busy0)
  );

  axi_rr_lock_mux #(.WIDTH(WIDTH), .NUM(NUM), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready1),
    .dst_valid(dst_valid1), .dst_data(dst_data1), .dst_last(dst_last1), .dst_ready(dst_ready1),
    .grant(grant1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic l, input logic [WIDTH-1:0] d);
    beat_t b;
    b.v = 1'b1;
    b.l = l;
    b.d = d;
    return b;
  endfunction

  function automatic beat_t bubble();
    beat_t b;
    b = '0;
    return b;
  endfunction

  task automatic expect_both(input logic l, input logic [WIDTH-1:0] d);
    exp0.push_back({l, d});
    exp1.push_back({l, d});
  endtask

  task automatic wait_drain(input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    while ((exp1.size() != 0 || (mon0_en && exp0.size() != 0)) && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_exp1", exp1.size(), 0);
    if (mon0_en) check("drain_exp0", exp0.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are judged mid-cycle, when ready/valid are settled.
  always @(negedge clk) hs = src_valid & (bp_phase ? src_ready1 : src_ready0);

  // Source drivers: one queue per source; a bubble entry idles that source one cycle.
  initial begin
    src_valid = '0;
    src_last  = '0;
    for (int i = 0; i < NUM; i++) src_data[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++) begin
        if (pres_bub[i] || (pres_beat[i] && hs[i])) void'(srcq[i].pop_front());
        pres_bub[i]  = 1'b0;
        pres_beat[i] = 1'b0;
        src_valid[i] = 1'b0;
        src_last[i]  = 1'b0;
        if (srcq[i].size() != 0) begin
          if (srcq[i][0].v) begin
            src_valid[i] = 1'b1;
            src_last[i]  = srcq[i][0].l;
            src_data[i]  = srcq[i][0].d;
            pres_beat[i] = 1'b1;
          end else begin
            pres_bub[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (mon0_en && dst_valid0 && dst_ready0) begin
      check("out0_pending", exp0.size() != 0, 1);
      if (exp0.size() != 0) begin
        e = exp0.pop_front();
        check("out0_beat", {dst_last0, dst_data0}, e);
      end
      stamps.push_back('{cyc: cyc, g: grant0});
    end
    if (dst_valid1 && dst_ready1) begin
      check("out1_pending", exp1.size() != 0, 1);
      if (exp1.size() != 0) begin
        e = exp1.pop_front();
        check("out1_beat", {dst_last1, dst_data1}, e);
      end
    end
    if (stall_prev) check("out1_stable", {dst_valid1, dst_last1, dst_data1}, out1_prev);
    out1_prev  = {dst_valid1, dst_last1, dst_data1};
    stall_prev = dst_valid1 && !dst_ready1 && !rst;
  end

  initial begin
    logic [3:0] bp_pat;
    logic [3:0] bp_rdy;

    rst        = 1'b1;
    dst_ready0 = 1'b1;
    dst_ready1 = 1'b1;

    // Reset with every source requesting, then two-beat bursts in RR order.
    for (int i = 0; i < NUM; i++) begin
      srcq[i].push_back(mk(1'b0, 8'h10 + 8'(2 * i)));
      srcq[i].push_back(mk(1'b1, 8'h11 + 8'(2 * i)));
      expect_both(1'b0, 8'h10 + 8'(2 * i));
      expect_both(1'b1, 8'h11 + 8'(2 * i));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_valid", src_valid, 4'b1111);
    check("rst_grant0", grant0, 4'b0000);
    check("rst_grant1", grant1, 4'b0000);
    check("rst_ready0", src_ready0, 4'b0000);
    check("rst_ready1", src_ready1, 4'b0000);
    check("rst_dvalid0", dst_valid0, 1'b0);
    check("rst_dvalid1", dst_valid1, 1'b0);
    check("rst_ddata0", dst_data0, 8'h00);
    check("rst_busy0", busy0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rel_grant0", grant0, 4'b0001);
    check("rel_grant1", grant1, 4'b0001);
    check("rel_busy0", busy0, 1'b1);
    check("rel_busy1", busy1, 1'b1);
    wait_drain(200);

    // Round-robin fairness with single-beat bursts.
    @(negedge clk);
    #1;
    stamps.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM; i++) begin
        srcq[i].push_back(mk(1'b1, 8'hA0 + 8'(i)));
        expect_both(1'b1, 8'hA0 + 8'(i));
      end
    wait_drain(200);
    check("rr_count", stamps.size(), 8);
    for (int i = 1; i < 8; i++)
      if (i < stamps.size()) check("rr_gap", stamps[i].cyc - stamps[i-1].cyc, 2);

    // Burst lock: src0 three beats while src2 waits.
    @(negedge clk);
    #1;
    stamps.delete();
    srcq[2].push_back(mk(1'b1, 8'hC2));
    for (int b = 0; b < 3; b++) begin
      srcq[0].push_back(mk(b == 2, 8'hB1 + 8'(b)));
      expect_both(b == 2, 8'hB1 + 8'(b));
    end
    expect_both(1'b1, 8'hC2);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      if (grant0 == 4'b0001) check("lock_src2_ready", src_ready0[2], 1'b0);
    end
    wait_drain(100);
    check("lock_count", stamps.size(), 4);
    if (stamps.size() >= 4) begin
      check("lock_gap1", stamps[1].cyc - stamps[0].cyc, 1);
      check("lock_gap2", stamps[2].cyc - stamps[1].cyc, 1);
      check("lock_gap3", stamps[3].cyc - stamps[2].cyc, 2);
      check("lock_grant_a", stamps[0].g, 4'b0001);
      check("lock_grant_b", stamps[3].g, 4'b0100);
    end

    // Pointer wrap: src3 alone, then src0 and src3 together.
    @(negedge clk);
    #1;
    srcq[3].push_back(mk(1'b1, 8'h83));
    expect_both(1'b1, 8'h83);
    wait_drain(50);
    @(negedge clk);
    #1;
    stamps.delete();
    srcq[0].push_back(mk(1'b1, 8'h80));
    srcq[3].push_back(mk(1'b1, 8'h84));
    expect_both(1'b1, 8'h80);
    expect_both(1'b1, 8'h84);
    wait_drain(50);
    check("wrap_count", stamps.size(), 2);
    if (stamps.size() >= 2) begin
      check("wrap_first", stamps[0].g, 4'b0001);
      check("wrap_second", stamps[1].g, 4'b1000);
    end

    // Async reset mid-burst while src1 pauses between beats 2 and 3.
    @(negedge clk);
    #1;
    srcq[1].push_back(mk(1'b0, 8'h51));
    srcq[1].push_back(mk(1'b0, 8'h52));
    for (int i = 0; i < 5; i++) srcq[1].push_back(bubble());
    srcq[1].push_back(mk(1'b0, 8'h53));
    srcq[1].push_back(mk(1'b1, 8'h54));
    expect_both(1'b0, 8'h51);
    expect_both(1'b0, 8'h52);
    wait_drain(50);
    @(posedge clk);
    #2;
    check("pre_rst_grant0", grant0, 4'b0010);
    check("pre_rst_busy1", busy1, 1'b1);
    rst = 1'b1;
    srcq[0].push_back(mk(1'b1, 8'h60));
    #1;
    check("arst_grant0", grant0, 4'b0000);
    check("arst_grant1", grant1, 4'b0000);
    check("arst_busy0", busy0, 1'b0);
    check("arst_busy1", busy1, 1'b0);
    check("arst_ready0", src_ready0, 4'b0000);
    check("arst_ready1", src_ready1, 4'b0000);
    check("arst_dvalid1", dst_valid1, 1'b0);
    check("arst_ddata1", {dst_last1, dst_data1}, 9'h000);
    stamps.delete();
    expect_both(1'b1, 8'h60);
    expect_both(1'b0, 8'h53);
    expect_both(1'b1, 8'h54);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_drain(100);
    check("arst_count", stamps.size(), 3);
    if (stamps.size() >= 2) begin
      check("arst_first", stamps[0].g, 4'b0001);
      check("arst_second", stamps[1].g, 4'b0010);
    end

    // Backpressure on the skid-slice instance only.
    @(negedge clk);
    #1;
    bp_phase = 1'b1;
    mon0_en  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      srcq[2].push_back(mk(b == 3, 8'h71 + 8'(b)));
      exp1.push_back({b == 3, 8'h71 + 8'(b)});
    end
    bp_pat = 4'b1001;
    bp_rdy = 4'b0011;
    begin
      int unsigned n;
      n = 0;
      while (!dst_valid1 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("bp_valid_seen", dst_valid1, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      dst_ready1 = bp_pat[i];
      @(negedge clk);
      check("bp_src_ready", src_ready1[2], bp_rdy[i]);
      @(posedge clk);
      #1;
    end
    dst_ready1 = 1'b1;
    wait_drain(50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_rr_lock_mux.md
Name: axi_rr_lock_mux

Overview:
- Parametrised successor to the crossbar's one-hot select/OR signal gate.
- Arbitrates NUM valid/ready/last source channels onto one sender channel using round-robin.
- Locks the grant for a whole burst, until the beat with last=1 handshakes.
- The data path stays a one-hot AND-OR mux; an optional full-throughput register slice sits on the output.

Parameters:
WIDTH, 8, payload width per channel in bits (>=1)
NUM, 4, number of source channels (>=2)
OUT_REG, 0, 0 = combinational output path; 1 = 2-entry skid slice on output (+1 cycle latency)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
src_valid  input  NUM  per-source beat valid
src_data  input  WIDTH x [0:NUM-1]  per-source payload (unpacked array)
src_last  input  NUM  per-source last-beat flag
src_ready  output  NUM  per-source ready; at most one bit high
dst_valid  output  1  sender-side valid
dst_data  output  WIDTH  sender-side payload
dst_last  output  1  sender-side last flag
dst_ready  input  1  sender-side ready
grant  output  NUM  registered one-hot current grant; all-zero when idle
busy  output  1  1 while in LOCKED state

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, busy=0, rr_ptr=0, src_ready=0, dst_valid=0, dst_data=0, dst_last=0, skid slice emptied.
- FSM states: IDLE, LOCKED.
- IDLE: if any src_valid is set, the winner is the first index i scanning from rr_ptr upward, modulo NUM. Next cycle: grant=onehot(i), state=LOCKED. No beat is accepted in the arbitration cycle (one bubble per burst).
- LOCKED, mux path: the granted source only is routed via AND-OR.
  - dst_data = OR over k of (grant[k] ? src_data[k] : 0); dst_last is formed the same way.
  - dst_valid = |(grant & src_valid).
  - src_ready = grant & {NUM{in_ready}}, where in_ready = dst_ready (OUT_REG=0) or slice-not-full (OUT_REG=1).
  - Non-granted src_ready are 0.
- Beat accepted = granted src_valid & in_ready.
- Accepted beat with last=1: next cycle state=IDLE, grant=0, rr_ptr=(i+1) mod NUM (wrap from NUM-1 to 0).
- Source drop: if the granted source drops valid mid-burst, the grant is held. There is no timeout or pre-emption.
- Input changes while LOCKED: requests from other sources are ignored.
- Simultaneous requests in IDLE: resolved only by rr_ptr; a source never waits more than NUM-1 bursts.
- Single-beat burst (last on first beat): LOCKED lasts exactly 1 cycle if in_ready=1.
- OUT_REG=1, 2-entry skid slice:
  - in_ready = slice has fewer than 2 entries (registered), and dst_valid is the slice head.
  - Sustains 1 beat/cycle under continuous dst_ready.
  - dst_ready low: slice holds its data stable and keeps dst_valid high until the handshake.
  - Lock release follows the source-side handshake of the last beat, so the slice may still drain while the next arbitration runs.
- OUT_REG=0: the dst_* path is purely combinational from src_*; no register between the inputs and dst_*.
- Stability: dst_valid/data/last must not change while dst_valid=1 and dst_ready=0, provided the source obeys AXI stability.
- Reset mid-burst: everything returns to reset values immediately. The partial burst is discarded, and rr_ptr restarts at 0.
- Widths: the index calculation uses $clog2(NUM) bits. NUM is not required to be a power of 2; wrap is by explicit compare to NUM-1.

Test Plan:
- Reset/idle: hold rst=1, all src_valid=1. Expect grant=0, src_ready=0, dst_valid=0. Release rst: grant=4'b0001 on the 2nd edge, busy=1.
- Round-robin fairness: NUM=4, all sources send continuous 1-beat bursts (data=0xA0+i), dst_ready=1.
  - Expect dst_data sequence A0,A1,A2,A3,A0.
  - Exactly one idle cycle between beats.
- Burst lock: src0 sends 3 beats (last on beat 3) while src2 is valid throughout. Expect 3 beats from src0 contiguous, then grant=4'b0100 and src2 data out. src2 src_ready stays 0 during the lock.
- Backpressure: OUT_REG=1, dst_ready toggled 1,0,0,1 during a 4-beat burst.
  - Expect no lost or duplicated beats.
  - dst_data held stable through the stall.
  - src_ready drops once 2 entries are buffered.
- Wrap and pointer: grant src3 (NUM=4) via a single burst, then src0 and src3 both request. Expect src0 wins next (rr_ptr wrapped to 0).
- Async reset mid-burst: assert rst between beats 2 and 3 of a src1 burst. Expect outputs to zero without waiting for a clock edge; after release, src0 (if valid) wins first.
